// File: rtl/processor_pkg.sv
// Definitions shared between the boot loader and the single-cycle core:
// loader state encoding and the instruction memory size.
package processor_pkg;

  localparam int IMEM_DEPTH = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/imem_boot_loader.sv
// Receives a length/payload/checksum frame, writes the payload bytes into the
// instruction memory in order and holds the core until the image is verified.
module imem_boot_loader
  import processor_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   byte_count
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t     state;
  state_t     state_nxt;
  logic [7:0] len;
  logic [7:0] sum;
  logic [7:0] sum_add;
  logic       xfer;
  logic       last_byte;
  logic       start_ok;

  // Length must be non-zero, fit in memory and cover whole 32-bit words.
  function automatic logic len_ok(input logic [7:0] l);
    return (l != 8'd0) && ({1'b0, l} <= 9'(DEPTH)) && (l[1:0] == 2'b00);
  endfunction

  assign rx_ready  = (state == LEN) || (state == DATA) || (state == CSUM);
  assign xfer      = rx_valid && rx_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign sum_add   = sum + rx_data;
  assign last_byte = ((9'(byte_count) + 9'd1) == {1'b0, len});

  assign done     = (state == DONE);
  assign error    = (state == ERR);
  assign cpu_hold = (state != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start_ok) state_nxt = LEN;
      LEN:             if (xfer) state_nxt = len_ok(rx_data) ? DATA : ERR;
      DATA:            if (xfer && last_byte) state_nxt = CSUM;
      CSUM:            if (xfer) state_nxt = (sum_add == 8'd0) ? DONE : ERR;
      default:         state_nxt = IDLE;
    endcase
  end

  // Write stage: a DATA transfer becomes a memory write in the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'd0;
      byte_count <= '0;
      len        <= 8'd0;
      sum        <= 8'd0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        byte_count <= '0;
        sum        <= 8'd0;
      end
      if ((state == LEN) && xfer) begin
        len <= rx_data;
        sum <= rx_data;
      end
      if ((state == DATA) && xfer) begin
        mem_we     <= 1'b1;
        mem_addr   <= byte_count[ADDR_W-1:0];
        mem_wdata  <= rx_data;
        byte_count <= byte_count + CNT_ONE;
        sum        <= sum_add;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: fixed vector table, hand-written
// corner sequences and randomized frames checked against a frame-level model.
module tb_imem_boot_loader;
  import processor_pkg::*;

  localparam int DEPTH  = IMEM_DEPTH;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   byte_count;

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] dut_mem [DEPTH];
  logic [7:0] frame_buf [258];
  int         wr_addr [$];
  int         wr_data [$];

  logic [7:0] nom [10] = '{8'h08, 8'h8C, 8'h04, 8'h00, 8'h00,
                           8'h01, 8'h05, 8'h30, 8'h20, 8'h12};

  typedef struct {
    int         len;
    logic [7:0] seed;
    logic [7:0] step;
    logic [7:0] delta;
    int         gap;
    bit         exp_done;
    int         exp_wr;
  } vec_t;

  vec_t vecs [9] = '{
    '{4,   8'h10, 8'h01, 8'h00, 0, 1'b1, 4},
    '{32,  8'hA5, 8'h07, 8'h00, 1, 1'b1, 32},
    '{12,  8'h00, 8'h00, 8'h01, 0, 1'b0, 12},
    '{3,   8'h11, 8'h01, 8'h00, 0, 1'b0, 0},
    '{0,   8'h11, 8'h01, 8'h00, 0, 1'b0, 0},
    '{36,  8'h11, 8'h01, 8'h00, 0, 1'b0, 0},
    '{255, 8'h11, 8'h01, 8'h00, 0, 1'b0, 0},
    '{16,  8'hFF, 8'h11, 8'h00, 2, 1'b1, 16},
    '{28,  8'h33, 8'h05, 8'h80, 0, 1'b0, 28}
  };

  // Capture every write the DUT performs into a log and a memory image.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(int'(mem_wdata));
      dut_mem[mem_addr] = mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit legal_len(input int l);
    return (l > 0) && (l <= DEPTH) && (l % 4 == 0);
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rx_ready) begin
      check("rx_ready_timeout", 32'd0, 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Frame = length byte, len payload bytes, checksum making the total zero
  // (offset by delta). Illegal lengths carry no body.
  task automatic build_frame(input int len, input logic [7:0] seed, input logic [7:0] step,
                             input logic [7:0] delta, input bit rnd);
    int s;
    frame_buf[0] = 8'(len);
    s = len;
    if (legal_len(len)) begin
      for (int i = 0; i < len; i++) begin
        frame_buf[i+1] = rnd ? 8'($urandom) : 8'(int'(seed) + int'(step) * i);
        s += frame_buf[i+1];
      end
      frame_buf[len+1] = 8'(256 - (s % 256) + int'(delta));
    end
  endtask

  task automatic run_frame(input int len, input int gap, input bit do_start);
    int n;
    wr_addr.delete();
    wr_data.delete();
    if (do_start) pulse_start();
    n = legal_len(len) ? len + 2 : 1;
    for (int i = 0; i < n; i++) send_byte(frame_buf[i], (i == n - 1) ? 0 : gap);
  endtask

  task automatic check_frame(input string tag, input bit exp_done, input int exp_wr);
    int mism = 0;
    check({tag, " done"}, 32'(done), 32'(exp_done));
    check({tag, " error"}, 32'(error), 32'(!exp_done));
    check({tag, " cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    check({tag, " byte_count"}, 32'(byte_count), 32'(exp_wr));
    check({tag, " write_count"}, 32'(wr_addr.size()), 32'(exp_wr));
    for (int i = 0; i < wr_addr.size() && i < exp_wr; i++)
      if (wr_addr[i] != i || wr_data[i] != int'(frame_buf[i+1])) mism++;
    check({tag, " write_data"}, 32'(mism), 32'd0);
  endtask

  task automatic load_nominal();
    for (int i = 0; i < 10; i++) frame_buf[i] = nom[i];
  endtask

  initial begin
    int   len;
    int   s;
    bit   leg;
    bit   ok;
    logic [7:0] ill [3] = '{8'h05, 8'h00, 8'h24};

    // Reset state
    #1 rst_n = 1'b0;
    #10;
    check("rst cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst done", 32'(done), 32'd0);
    check("rst error", 32'(error), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    check("rst mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst byte_count", 32'(byte_count), 32'd0);
    check("rst rx_ready", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal load with release timing
    load_nominal();
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    for (int i = 0; i < 9; i++) send_byte(frame_buf[i], 0);
    check("nom pre_csum done", 32'(done), 32'd0);
    check("nom pre_csum cpu_hold", 32'(cpu_hold), 32'd1);
    send_byte(frame_buf[9], 0);
    check_frame("nominal", 1'b1, 8);
    check("nom word0", {dut_mem[0], dut_mem[1], dut_mem[2], dut_mem[3]}, 32'h8C040000);

    // Bad checksum
    load_nominal();
    frame_buf[9] = 8'h13;
    run_frame(8, 0, 1'b1);
    check_frame("bad_csum", 1'b0, 8);

    // Illegal lengths, then recovery
    for (int k = 0; k < 3; k++) begin
      wr_addr.delete();
      pulse_start();
      send_byte(ill[k], 0);
      check($sformatf("ill%0d error", k), 32'(error), 32'd1);
      check($sformatf("ill%0d rx_ready", k), 32'(rx_ready), 32'd0);
      repeat (2) begin @(posedge clk); #1; end
      check($sformatf("ill%0d writes", k), 32'(wr_addr.size()), 32'd0);
    end
    load_nominal();
    run_frame(8, 0, 1'b1);
    check_frame("recover", 1'b1, 8);

    // Gapped stream with a start pulse in the middle of DATA
    load_nominal();
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        send_byte(frame_buf[i], 0);
        pulse_start();
        repeat (2) begin @(posedge clk); #1; end
      end else begin
        send_byte(frame_buf[i], (i == 9) ? 0 : 3);
      end
    end
    check_frame("gapped", 1'b1, 8);

    // Reload from DONE
    pulse_start();
    check("reload cpu_hold", 32'(cpu_hold), 32'd1);
    check("reload done", 32'(done), 32'd0);
    build_frame(8, 8'h40, 8'h03, 8'h00, 1'b0);
    run_frame(8, 0, 1'b0);
    check_frame("reload", 1'b1, 8);
    check("reload word0", {dut_mem[0], dut_mem[1], dut_mem[2], dut_mem[3]},
          {frame_buf[1], frame_buf[2], frame_buf[3], frame_buf[4]});

    // Asynchronous reset after the 4th payload byte
    load_nominal();
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(frame_buf[i], 0);
    check("midrst writes_before", 32'(wr_addr.size()), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst cpu_hold", 32'(cpu_hold), 32'd1);
    check("midrst mem_we", 32'(mem_we), 32'd0);
    check("midrst byte_count", 32'(byte_count), 32'd0);
    check("midrst rx_ready", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (6) begin @(posedge clk); #1; end
    rx_valid = 1'b0;
    check("midrst rx_ready_after", 32'(rx_ready), 32'd0);
    check("midrst writes_after", 32'(wr_addr.size()), 32'd0);
    check("midrst done", 32'(done), 32'd0);

    // Vector table
    foreach (vecs[i]) begin
      build_frame(vecs[i].len, vecs[i].seed, vecs[i].step, vecs[i].delta, 1'b0);
      run_frame(vecs[i].len, vecs[i].gap, 1'b1);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_wr);
    end

    // Randomized frames against the frame-level model
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) == 0) len = int'($urandom_range(0, 255));
      else len = 4 * int'($urandom_range(1, DEPTH / 4));
      build_frame(len, 8'd0, 8'd0,
                  ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0, 1'b1);
      run_frame(len, int'($urandom_range(0, 2)), 1'b1);
      leg = legal_len(len);
      s = 0;
      if (leg) for (int i = 0; i < len + 2; i++) s += frame_buf[i];
      ok = leg && (s % 256 == 0);
      check_frame($sformatf("rand%0d", t), ok, leg ? len : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
